// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared types and helpers for the countdown time tracker.
//   cdState_t : controller state (IDLE / RUN / PAUSED / EXPIRED)
//   prescW()  : prescaler counter width for a given ticks-per-second value
//   cntW()    : counter width for 0..n-1, never narrower than one bit
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } cdState_t;

  function automatic int prescW(input int ticks);
    return (ticks < 2) ? 1 : $clog2(ticks);
  endfunction

  function automatic int cntW(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides clk down to a one-second tick.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   run  : counter runs while high, clears to 0 while low
//   hold : freezes the count (a tick that would fire is swallowed)
//   tick : one-cycle strobe in the cycle the count sits at TICKS_PER_SEC-1
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int            PW   = prescW(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] cnt;

  assign tick = run && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (!run)  cnt <= '0;
    else if (!hold) cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
  end

endmodule

// File: rtl/countdown_time_tracker.sv
// countdown_time_tracker
// Game time-limit countdown. Loads a start value while idle, then steps the
// remaining time down by one every SEC_PER_STEP seconds of unpaused run time.
// Supports pause, saturating bonus-time add and a latched timeout flag.
// Optional feature macro: COUNTDOWN_WARN_EN (low-time blink on warn).
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   enable     : 0 = hold/reload, 1 = run
//   pause      : freezes the countdown while high
//   start_time : load value, 0 selects DEFAULT_TIME
//   add_valid  : single-cycle bonus-time request
//   add_amount : bonus amount
//   time_out   : remaining time
//   timeout    : high while expired
//   step_pulse : one-cycle strobe on each decrement
//   warn       : low-time blink (constant 0 without the macro)
module countdown_time_tracker
  import countdown_pkg::*;
#(
  parameter int TIME_W        = 4,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_PER_STEP  = 5,
  parameter int DEFAULT_TIME  = 10,
  parameter int WARN_LEVEL    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pause,
  input  logic [TIME_W-1:0] start_time,
  input  logic              add_valid,
  input  logic [TIME_W-1:0] add_amount,
  output logic [TIME_W-1:0] time_out,
  output logic              timeout,
  output logic              step_pulse,
  output logic              warn
);

  localparam int                SW       = cntW(SEC_PER_STEP);
  localparam logic [SW-1:0]     SEC_LAST = SW'(SEC_PER_STEP - 1);
  localparam logic [TIME_W:0]   TMAX     = {1'b0, {TIME_W{1'b1}}};
  localparam logic [TIME_W-1:0] DEF_T    = TIME_W'(DEFAULT_TIME);

  cdState_t          state, nextState;
  logic              active, cntRun, secTick, stepNow, addNow, expire;
  logic [SW-1:0]     secCnt;
  logic [TIME_W-1:0] loadVal, satTime;
  logic [TIME_W:0]   sumWide;
  logic [TIME_W-1:0] timeNext;
  logic              timeoutNext, stepNext;

  // Counters only advance while a countdown is live; dropping enable or
  // reaching EXPIRED clears them on the next edge.
  assign active = (state == RUN) || (state == PAUSED);
  assign cntRun = enable && active;

  tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) uPresc (
    .clk  (clk),
    .rst  (rst),
    .run  (cntRun),
    .hold (pause),
    .tick (secTick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         secCnt <= '0;
    else if (!cntRun) secCnt <= '0;
    else if (secTick) secCnt <= (secCnt == SEC_LAST) ? '0 : secCnt + SW'(1);
  end

  assign loadVal = (start_time == '0) ? DEF_T : start_time;
  // time_out is never 0 while live; the guard just makes underflow impossible.
  assign stepNow = secTick && (secCnt == SEC_LAST) && (time_out != '0);
  assign addNow  = cntRun && add_valid;

  // Add and decrement are merged in one extra bit so the saturation sees the
  // true sum before the step is taken off.
  assign sumWide = {1'b0, time_out}
                 + (addNow ? {1'b0, add_amount} : '0)
                 - {{TIME_W{1'b0}}, stepNow};
  assign satTime = (sumWide > TMAX) ? {TIME_W{1'b1}} : sumWide[TIME_W-1:0];
  assign expire  = cntRun && (satTime == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    if (!enable) nextState = IDLE;
    else begin
      unique case (state)
        IDLE:    nextState = RUN;
        RUN:     nextState = expire ? EXPIRED : (pause ? PAUSED : RUN);
        PAUSED:  nextState = expire ? EXPIRED : (pause ? PAUSED : RUN);
        EXPIRED: nextState = EXPIRED;
        default: nextState = IDLE;
      endcase
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    timeNext    = time_out;
    timeoutNext = timeout;
    stepNext    = 1'b0;
    if (!enable || (state == IDLE)) begin
      timeNext    = loadVal;
      timeoutNext = 1'b0;
    end else if (state == EXPIRED) begin
      timeNext    = '0;
      timeoutNext = 1'b1;
    end else begin
      timeNext    = satTime;
      timeoutNext = expire;
      stepNext    = stepNow;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_out   <= '0;
      timeout    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      time_out   <= timeNext;
      timeout    <= timeoutNext;
      step_pulse <= stepNext;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  localparam logic [TIME_W:0] WARN_LVL = (TIME_W+1)'(WARN_LEVEL);

  logic warnQ, lowNow, lowNext;

  assign lowNow  = (time_out != '0) && ({1'b0, time_out} <= WARN_LVL);
  assign lowNext = (timeNext != '0) && ({1'b0, timeNext} <= WARN_LVL);

  // Cleared outside a live countdown or above the threshold; otherwise it
  // toggles per second and simply holds while the prescaler is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             warnQ <= 1'b0;
    else if (!cntRun || !lowNext)         warnQ <= 1'b0;
    else if (secTick && lowNow)           warnQ <= ~warnQ;
  end

  assign warn = warnQ;
`else
  // No blink logic; the threshold folds away to a constant 0.
  assign warn = 1'b0 && (WARN_LEVEL > 0);
`endif

endmodule

// File: doc/countdown_time_tracker.md
# countdown_time_tracker

Parametrised countdown timer for the game's time-limit display. It loads a start value while idle, then decrements once every SEC_PER_STEP seconds of run time. It supports pause, bonus-time add with saturation, and a latched timeout flag. It feeds the LED/7-seg time display and the game-over logic, and adds a step strobe and an optional low-time warning blink.

## Interface
Parameters:
- TIME_W, 4: width of the time value.
- TICKS_PER_SEC, 50_000_000: clk cycles per one-second tick. Must be ≥ 2.
- SEC_PER_STEP, 5: seconds per time decrement. Must be ≥ 1.
- DEFAULT_TIME, 10: value loaded when start_time == 0. Must be nonzero and < 2^TIME_W.
- WARN_LEVEL, 3: warning threshold. Only used with COUNTDOWN_WARN_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  0 = hold/reload, 1 = run.
- pause  in  1  freezes the countdown while high.
- start_time  in  TIME_W  load value; 0 means use DEFAULT_TIME.
- add_valid  in  1  single-cycle bonus-time request.
- add_amount  in  TIME_W  bonus amount.
- time_out  out  TIME_W  current remaining time.
- timeout  out  1  high while expired.
- step_pulse  out  1  one-cycle strobe on each decrement.
- warn  out  1  low-time blink; tied 0 without the macro.

## Operation
- **Reset** (rst low, async): every output is 0; state = IDLE; prescaler and second counter = 0.
- **States:** IDLE, RUN, PAUSED, EXPIRED.
- **enable = 0** from any state → IDLE.
  - In IDLE, every cycle: time_out ← (start_time == 0 ? DEFAULT_TIME : start_time).
  - Prescaler, second counter, timeout, step_pulse and warn are all 0.
- **IDLE → RUN** when enable = 1. time_out holds its last loaded value.
- **RUN:**
  - The prescaler counts 0..TICKS_PER_SEC-1. The cycle it is at TICKS_PER_SEC-1 is a sec_tick, and it wraps to 0.
  - On each sec_tick the second counter increments.
  - When a sec_tick occurs with second counter == SEC_PER_STEP-1: second counter ← 0, time_out ← time_out-1, step_pulse = 1 for one cycle.
- **RUN ↔ PAUSED:**
  - pause = 1 moves RUN → PAUSED. Prescaler and second counter freeze.
  - pause = 0 returns to RUN, resuming from the frozen counts.
  - pause is ignored in IDLE and EXPIRED.
- **Bonus time** (add_valid = 1 in RUN or PAUSED):
  - time_out ← min(time_out + add_amount, 2^TIME_W-1). Compute in TIME_W+1 bits.
  - Same cycle as a decrement: time_out ← sat(time_out + add_amount - 1).
  - add_valid is ignored in IDLE and EXPIRED.
- **RUN → EXPIRED** when the next time_out value is 0. This includes decrement from 1 with add_amount = 0 or no add.
  - EXPIRED: time_out = 0, timeout = 1, counters cleared, held until enable = 0.
- **Underflow** is impossible: a decrement never occurs from 0.

## Timing
- All outputs are registered.
- timeout rises on the same edge that time_out becomes 0.
- First decrement occurs TICKS_PER_SEC × SEC_PER_STEP cycles after the first RUN cycle. Later decrements occur at the same interval, excluding PAUSED cycles.
- step_pulse is coincident with the edge that updates time_out.
- pause, add_valid and enable act on the next edge: one-cycle latency.
- A pause and a sec_tick in the same cycle: pause wins, and the tick is not counted.
- enable falling mid-run: the next edge reloads and clears all counters. Progress is not retained.

## Configuration
- **COUNTDOWN_WARN_EN defined:**
  - In RUN, while 0 < time_out ≤ WARN_LEVEL, warn toggles on every sec_tick.
  - warn is forced to 0 on reset, in IDLE and in EXPIRED, and whenever time_out > WARN_LEVEL.
  - In PAUSED, warn holds its value.
- **Undefined:** warn is constant 0 and no toggle flop is generated.

## Structure
- Package countdown_pkg holds:
  - the state typedef (IDLE/RUN/PAUSED/EXPIRED);
  - the prescaler width function, $clog2(TICKS_PER_SEC).
- Sub-module tick_prescaler is parametrised by TICKS_PER_SEC.
  - Inputs: clk, rst, run (clear when low), hold.
  - Output: one-cycle tick.

## Test plan
Bench parameters: TICKS_PER_SEC=4, SEC_PER_STEP=2, TIME_W=4 unless noted.

- **Reset and load:** rst low mid-count → all outputs 0 immediately; release with enable=0, start_time=0 → time_out=10.
- **Countdown:** start_time=3, then enable=1 → step_pulse and time_out=2 after 8 cycles, 1 after 16, 0 with timeout=1 after 24. Outputs hold until enable=0.
- **Pause:** pause for 5 cycles mid-step → the decrement is delayed by exactly 5 cycles.
- **Bonus time:**
  - time_out=14, add_amount=5 → 15 (saturated).
  - time_out=4, add 2 on the decrement cycle → 5.
- **Abort:** enable drops at time_out=2 → next cycle time_out=start_time, timeout=0. Re-enable → full 8-cycle first step.
- **Warning (COUNTDOWN_WARN_EN, WARN_LEVEL=3):** warn toggles every 4 cycles once time_out ≤ 3; warn=0 at expiry. Without the macro, warn stays 0 throughout.
